// File: rtl/bp_fpga_host_uart_rx.sv
// bp_fpga_host_uart_rx: UART receiver with mid-bit sampling, parity/framing checks and a one-entry output buffer.
// Define BP_FPGA_HOST_UART_RX_SYNC_EN to double-flop rx_i (hardware builds).
module bp_fpga_host_uart_rx #(
  parameter int uart_clk_per_bit_p = 10416,
  parameter int uart_data_bits_p = 8,
  parameter int uart_parity_bit_p = 0,
  parameter int uart_parity_odd_p = 0,
  parameter int uart_stop_bits_p = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic rx_i,
  output logic [uart_data_bits_p-1:0] data_o,
  output logic v_o,
  input  logic ready_and_i,
  output logic parity_err_o,
  output logic frame_err_o,
  output logic overrun_o
);
  localparam int cw_lp = $clog2(uart_clk_per_bit_p + 1);
  localparam logic [cw_lp-1:0] bit_last_lp = cw_lp'(uart_clk_per_bit_p - 1);
  localparam logic [cw_lp-1:0] half_last_lp = cw_lp'(uart_clk_per_bit_p / 2 - 1);
  localparam logic [3:0] data_last_lp = 4'(uart_data_bits_p - 1);
  localparam logic [3:0] stop_last_lp = 4'(uart_stop_bits_p - 1);
  localparam logic parity_en_lp = uart_parity_bit_p != 0;
  localparam logic odd_lp = uart_parity_odd_p != 0;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  state_e state_r, state_n;
  logic [cw_lp-1:0] cnt_r, cnt_n;
  logic [3:0] idx_r, idx_n;
  logic [uart_data_bits_p-1:0] shift_r, shift_n;
  logic perr_r, perr_n, ferr_r, ferr_n, armed_r, done, fe_now, deliver, rx_s;
`ifdef BP_FPGA_HOST_UART_RX_SYNC_EN
  logic [1:0] sync_r;
  always_ff @(posedge clk_i)
    sync_r <= reset_i ? 2'b11 : {sync_r[0], rx_i};
  assign rx_s = sync_r[1];
`else
  assign rx_s = rx_i;
`endif
  assign fe_now = ferr_r | ~rx_s;
  assign deliver = done & ~fe_now & ~perr_r;
  always_comb begin
    state_n = state_r;
    cnt_n = cnt_r + 1'b1;
    idx_n = idx_r;
    shift_n = shift_r;
    perr_n = perr_r;
    ferr_n = ferr_r;
    done = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        perr_n = 1'b0;
        ferr_n = 1'b0;
        state_n = (~rx_s & armed_r) ? START : IDLE;
      end
      START: if (cnt_r == half_last_lp) begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt_r == bit_last_lp) begin
        cnt_n = '0;
        shift_n = {rx_s, shift_r[uart_data_bits_p-1:1]};
        idx_n = (idx_r == data_last_lp) ? 4'd0 : idx_r + 1'b1;
        state_n = (idx_r != data_last_lp) ? DATA : parity_en_lp ? PARITY : STOP;
      end
      PARITY: if (cnt_r == bit_last_lp) begin
        cnt_n = '0;
        perr_n = ((^shift_r) ^ rx_s) != odd_lp;
        state_n = STOP;
      end
      STOP: if (cnt_r == bit_last_lp) begin
        cnt_n = '0;
        ferr_n = fe_now;
        done = idx_r == stop_last_lp;
        idx_n = done ? 4'd0 : idx_r + 1'b1;
        state_n = done ? IDLE : STOP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      cnt_r <= '0;
      idx_r <= '0;
      shift_r <= '0;
      perr_r <= 1'b0;
      ferr_r <= 1'b0;
      armed_r <= 1'b0;
      data_o <= '0;
      v_o <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r <= cnt_n;
      idx_r <= idx_n;
      shift_r <= shift_n;
      perr_r <= perr_n;
      ferr_r <= ferr_n;
      // a start bit only counts once the line has been seen idle after reset
      armed_r <= armed_r | rx_s;
      frame_err_o <= done & fe_now;
      parity_err_o <= done & ~fe_now & perr_r;
      overrun_o <= deliver & v_o & ~ready_and_i;
      if (deliver & (~v_o | ready_and_i)) begin
        data_o <= shift_r;
        v_o <= 1'b1;
      end else if (v_o & ready_and_i) begin
        v_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bp_fpga_host_uart_rx.sv
// tb_bp_fpga_host_uart_rx: drives UART frames into an 8N1 receiver (index 0) and an 8E2 receiver (index 1).
module tb_bp_fpga_host_uart_rx;
  localparam int cpb = 16;
  logic clk = 0;
  logic reset = 1;
  logic rx [2];
  logic rdy [2];
  logic [7:0] data [2];
  logic v [2], pe [2], fe [2], ov [2];
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] got_a [$];
  logic [7:0] got_b [$];
  int fe_n [2], pe_n [2], ov_n [2], rise_cyc [2];
  logic v_d [2], rdy_d [2];
  logic [7:0] data_d [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bp_fpga_host_uart_rx #(.uart_clk_per_bit_p(cpb)) dut_a (
    .clk_i(clk), .reset_i(reset), .rx_i(rx[0]), .data_o(data[0]), .v_o(v[0]), .ready_and_i(rdy[0]),
    .parity_err_o(pe[0]), .frame_err_o(fe[0]), .overrun_o(ov[0]));
  bp_fpga_host_uart_rx #(.uart_clk_per_bit_p(cpb), .uart_parity_bit_p(1), .uart_parity_odd_p(0),
    .uart_stop_bits_p(2)) dut_b (
    .clk_i(clk), .reset_i(reset), .rx_i(rx[1]), .data_o(data[1]), .v_o(v[1]), .ready_and_i(rdy[1]),
    .parity_err_o(pe[1]), .frame_err_o(fe[1]), .overrun_o(ov[1]));

  // monitor: handshakes, pulse counts, hold stability and pulse exclusivity
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        if (v[i] && rdy[i]) begin
          if (i == 0) got_a.push_back(data[i]);
          else got_b.push_back(data[i]);
        end
        if (v[i] && !v_d[i]) rise_cyc[i] = cyc;
        fe_n[i] += int'(fe[i]);
        pe_n[i] += int'(pe[i]);
        ov_n[i] += int'(ov[i]);
        if (v_d[i] && !rdy_d[i]) begin
          checks++;
          if (!v[i] || data[i] !== data_d[i]) begin
            errors++;
            $display("FAIL hold%0d: v=%b data=%h, required v=1 data=%h", i, v[i], data[i], data_d[i]);
          end
        end
        if (fe[i] || pe[i] || ov[i]) begin
          checks++;
          if (int'(fe[i]) + int'(pe[i]) + int'(ov[i]) != 1) begin
            errors++;
            $display("FAIL excl%0d: fe=%b pe=%b ov=%b, required one pulse", i, fe[i], pe[i], ov[i]);
          end
        end
      end
      v_d[i] = v[i];
      rdy_d[i] = rdy[i];
      data_d[i] = data[i];
    end
  end

  task automatic drive(input int i, input logic b, input int n);
    rx[i] = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic p, input logic s0, input logic s1);
    drive(i, 1'b0, cpb);
    for (int k = 0; k < 8; k++) drive(i, d[k], cpb);
    if (i == 1) drive(i, p, cpb);
    drive(i, s0, cpb);
    if (i == 1) drive(i, s1, cpb);
    drive(i, 1'b1, cpb);
  endtask

  task automatic consume(input int i);
    rdy[i] = 1;
    @(posedge clk);
    #1;
    rdy[i] = 0;
  endtask

  task automatic check_counts(input string name, input int i, input int f0, input int p0, input int o0,
                              input int df, input int dp, input int dovr);
    checks++;
    if (fe_n[i] - f0 != df || pe_n[i] - p0 != dp || ov_n[i] - o0 != dovr) begin
      errors++;
      $display("FAIL %s: fe/pe/ov=%0d/%0d/%0d, required %0d/%0d/%0d", name,
               fe_n[i] - f0, pe_n[i] - p0, ov_n[i] - o0, df, dp, dovr);
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (v[i] !== 0 || data[i] !== 8'h00 || pe[i] !== 0 || fe[i] !== 0 || ov[i] !== 0) begin
        errors++;
        $display("FAIL reset%0d: v=%b data=%h pe=%b fe=%b ov=%b, required all 0", i, v[i], data[i], pe[i], fe[i], ov[i]);
      end
    end
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_latency;
    int t0, f0, p0, o0;
    f0 = fe_n[0]; p0 = pe_n[0]; o0 = ov_n[0];
    t0 = cyc;
    send(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    checks++;
    if (rise_cyc[0] - t0 != 153) begin
      errors++;
      $display("FAIL latency: v rose at %0d, required 153", rise_cyc[0] - t0);
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (v[0] !== 1 || data[0] !== 8'hA5) begin
      errors++;
      $display("FAIL a5_hold: v=%b data=%h, required v=1 data=a5", v[0], data[0]);
    end
    check_counts("a5_pulses", 0, f0, p0, o0, 0, 0, 0);
    consume(0);
    checks++;
    if (v[0] !== 0 || got_a.size() == 0 || got_a[$] !== 8'hA5) begin
      errors++;
      $display("FAIL a5_consume: v=%b last=%h, required v=0 last=a5", v[0], got_a.size() ? got_a[$] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back;
    int f0, p0, o0, n0;
    f0 = fe_n[0]; p0 = pe_n[0]; o0 = ov_n[0];
    send(0, 8'h3C, 1'b0, 1'b1, 1'b1);
    send(0, 8'hC3, 1'b0, 1'b1, 1'b1);
    checks++;
    if (v[0] !== 1 || data[0] !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_stall: v=%b data=%h, required v=1 data=3c", v[0], data[0]);
    end
    check_counts("b2b_overrun", 0, f0, p0, o0, 0, 0, 1);
    consume(0);
    o0 = ov_n[0];
    n0 = got_a.size();
    rdy[0] = 1;
    send(0, 8'h3C, 1'b0, 1'b1, 1'b1);
    send(0, 8'hC3, 1'b0, 1'b1, 1'b1);
    checks++;
    if (got_a.size() != n0 + 2 || got_a[n0] !== 8'h3C || got_a[n0+1] !== 8'hC3) begin
      errors++;
      $display("FAIL b2b_flow: got %0d bytes, required 3c c3", got_a.size() - n0);
    end
    check_counts("b2b_no_overrun", 0, f0, p0, o0, 0, 0, 0);
  endtask

  task automatic test_glitch;
    int f0, p0, o0, n0;
    f0 = fe_n[0]; p0 = pe_n[0]; o0 = ov_n[0];
    n0 = got_a.size();
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 2 * cpb);
    checks++;
    if (v[0] !== 0 || got_a.size() != n0) begin
      errors++;
      $display("FAIL glitch: v=%b bytes=%0d, required v=0 bytes=0", v[0], got_a.size() - n0);
    end
    check_counts("glitch_pulses", 0, f0, p0, o0, 0, 0, 0);
    send(0, 8'h00, 1'b0, 1'b1, 1'b1);
    checks++;
    if (got_a.size() != n0 + 1 || got_a[$] !== 8'h00) begin
      errors++;
      $display("FAIL glitch_next: bytes=%0d, required one 00", got_a.size() - n0);
    end
  endtask

  task automatic test_frame_err;
    int f0, p0, o0, n0;
    f0 = fe_n[0]; p0 = pe_n[0]; o0 = ov_n[0];
    n0 = got_a.size();
    send(0, 8'h55, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b1, cpb);
    check_counts("stop_low", 0, f0, p0, o0, 1, 0, 0);
    checks++;
    if (got_a.size() != n0) begin
      errors++;
      $display("FAIL stop_low_drop: bytes=%0d, required 0", got_a.size() - n0);
    end
    send(0, 8'h55, 1'b0, 1'b1, 1'b1);
    checks++;
    if (got_a.size() != n0 + 1 || got_a[$] !== 8'h55) begin
      errors++;
      $display("FAIL stop_recover: bytes=%0d, required one 55", got_a.size() - n0);
    end
  endtask

  task automatic test_parity;
    int f0, p0, o0, n0;
    rdy[1] = 1;
    f0 = fe_n[1]; p0 = pe_n[1]; o0 = ov_n[1];
    n0 = got_b.size();
    send(1, 8'h01, 1'b1, 1'b1, 1'b1);
    checks++;
    if (got_b.size() != n0 + 1 || got_b[$] !== 8'h01) begin
      errors++;
      $display("FAIL parity_good: bytes=%0d, required one 01", got_b.size() - n0);
    end
    send(1, 8'h01, 1'b0, 1'b1, 1'b1);
    check_counts("parity_bad", 1, f0, p0, o0, 0, 1, 0);
    f0 = fe_n[1]; p0 = pe_n[1];
    send(1, 8'h01, 1'b1, 1'b1, 1'b0);
    drive(1, 1'b1, cpb);
    check_counts("stop2_low", 1, f0, p0, o0, 1, 0, 0);
    f0 = fe_n[1]; p0 = pe_n[1];
    send(1, 8'h01, 1'b0, 1'b1, 1'b0);
    drive(1, 1'b1, cpb);
    check_counts("frame_over_parity", 1, f0, p0, o0, 1, 0, 0);
    checks++;
    if (got_b.size() != n0 + 1) begin
      errors++;
      $display("FAIL parity_drop: bytes=%0d, required 1", got_b.size() - n0);
    end
  endtask

  task automatic test_reset_mid;
    int n0;
    n0 = got_a.size();
    drive(0, 1'b0, cpb);
    for (int k = 0; k < 4; k++) drive(0, 1'b1, cpb);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    drive(0, 1'b1, 6 * cpb);
    checks++;
    if (v[0] !== 0 || got_a.size() != n0) begin
      errors++;
      $display("FAIL reset_mid: v=%b bytes=%0d, required v=0 bytes=0", v[0], got_a.size() - n0);
    end
    send(0, 8'h81, 1'b0, 1'b1, 1'b1);
    checks++;
    if (got_a.size() != n0 + 1 || got_a[$] !== 8'h81) begin
      errors++;
      $display("FAIL reset_mid_next: bytes=%0d, required one 81", got_a.size() - n0);
    end
  endtask

  // reference: frame error if any stop bit low, else parity error if even parity fails, else byte delivered
  task automatic test_random;
    logic [7:0] exp_q [$];
    int f0, p0, o0, n0, ef, ep, kind;
    logic [7:0] d;
    logic p, s0, s1;
    f0 = fe_n[1]; p0 = pe_n[1]; o0 = ov_n[1];
    n0 = got_b.size();
    ef = 0;
    ep = 0;
    for (int n = 0; n < 30; n++) begin
      d = 8'($urandom);
      kind = $urandom_range(0, 5);
      p = (^d) ^ (kind == 0);
      s0 = kind != 1;
      s1 = kind != 2;
      if (!s0 || !s1) ef++;
      else if ((^d) ^ p) ep++;
      else exp_q.push_back(d);
      send(1, d, p, s0, s1);
      drive(1, 1'b1, $urandom_range(0, 3) + ((s0 && s1) ? 0 : cpb));
    end
    checks++;
    if (got_b.size() - n0 != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: bytes=%0d, required %0d", got_b.size() - n0, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (got_b[n0+k] !== exp_q[k]) begin
          errors++;
          $display("FAIL rand_byte%0d: got %h, required %h", k, got_b[n0+k], exp_q[k]);
        end
      end
    end
    check_counts("rand_pulses", 1, f0, p0, o0, ef, ep, 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rx[i] = 1;
      rdy[i] = 0;
      fe_n[i] = 0;
      pe_n[i] = 0;
      ov_n[i] = 0;
      rise_cyc[i] = 0;
    end
    test_reset;
    test_latency;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_parity;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
